seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/bcd7seg_dec.sv | 27 ++
 rtl/seven_seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment patterns and scan FSM state type for the seven-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, a in bit 6, active-high.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational BCD nibble to seven-segment pattern decoder.
// Non-BCD nibbles (10..15) produce a dark digit.
module bcd7seg_dec
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed BCD seven-segment scan controller with a shadow/active value pair swapped at frame boundaries.
// Optional build macro LEADING_ZERO_BLANK_EN darkens digits above the most significant nonzero digit.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [VW-1:0] V_LAST = VW'(REFRESH_DIV - 1);

    state_t                  state, state_nxt;
    logic [DW-1:0]           d, d_nxt;
    logic [VW-1:0]           div, div_nxt;
    logic [4*NUM_DIGITS-1:0] shadow, active;
    logic                    scan_start, update, blank;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg, seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    always_comb begin
        state_nxt  = state;
        d_nxt      = d;
        div_nxt    = div;
        scan_start = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt  = SCAN;
                    d_nxt      = '0;
                    div_nxt    = '0;
                    scan_start = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    d_nxt     = '0;
                    div_nxt   = '0;
                end else if (div == V_LAST) begin
                    div_nxt = '0;
                    d_nxt   = (d == D_LAST) ? '0 : d + DW'(1);
                end else begin
                    div_nxt = div + VW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign frame_done = (state == SCAN) && (d == D_LAST) && (div == V_LAST);
    // Active only changes at frame edges, so a frame is never drawn from two values.
    assign update     = scan_start | frame_done;

    always_comb begin
        nibble = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (d == DW'(k)) nibble = active[4*k +: 4];
        end
    end

    bcd7seg_dec u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [DW-1:0] msd;

    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (active[4*k +: 4] != 4'd0) msd = DW'(k);
        end
    end

    assign blank = (d > msd);
`else
    assign blank = 1'b0;
`endif

    assign seg_nxt = ((state == SCAN) && !blank) ? dec_seg : SEG_BLANK;
    assign an_nxt  = (state == SCAN) ? (NUM_DIGITS'(1) << d) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            d       <= '0;
            div     <= '0;
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            seg     <= SEG_BLANK;
            an      <= '0;
        end else begin
            state   <= state_nxt;
            d       <= d_nxt;
            div     <= div_nxt;
            if (load)   shadow <= bcd_in;
            if (update) active <= shadow;
            pending <= load | (pending & ~update);
            seg     <= seg_nxt;
            an      <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: directed scenarios plus randomized traffic against a frame-time model.
// Honors LEADING_ZERO_BLANK_EN when the same macro is defined for the build.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          rst, en, load;
    logic [4*N-1:0] bcd_in;
    logic [6:0]    seg;
    logic [N-1:0]  an;
    logic          frame_done, pending;

    int total = 0;
    int bad   = 0;

    // Model: scan time in cycles since entering scan, plus the value registers.
    bit            m_scan;
    int            m_t;
    logic [15:0]   m_shadow, m_active;
    logic          m_pending;
    logic [6:0]    m_seg;
    logic [3:0]    m_an;
    logic          exp_fd, obs_fd;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    function automatic logic model_fd();
        return m_scan && ((m_t % (N*R)) == N*R - 1);
    endfunction

    function automatic logic [6:0] ref_digit(input logic [15:0] val, input int k);
        int v;
        int msd;
        v = (val >> (4*k)) & 15;
        msd = 0;
        for (int j = 1; j < N; j++) if (((val >> (4*j)) & 15) != 0) msd = j;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > msd) return 7'b0000000;
`endif
        case (v)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_step(input logic e, input logic l, input logic [15:0] b, input logic r);
        logic fd;
        logic upd;
        int dd;
        fd = model_fd();
        if (r) begin
            m_scan = 0; m_t = 0; m_shadow = '0; m_active = '0;
            m_pending = 1'b0; m_seg = '0; m_an = '0;
            return;
        end
        dd = (m_t / R) % N;
        m_seg = m_scan ? ref_digit(m_active, dd) : 7'b0;
        m_an  = m_scan ? 4'(1 << dd) : 4'b0;
        upd = (m_scan && fd) || (!m_scan && e);
        if (upd) m_active = m_shadow;
        if (l) begin
            m_shadow  = b;
            m_pending = 1'b1;
        end else if (upd) begin
            m_pending = 1'b0;
        end
        if (!m_scan && e) begin
            m_scan = 1; m_t = 0;
        end else if (m_scan && !e) begin
            m_scan = 0;
        end else if (m_scan) begin
            m_t++;
        end
    endtask

    // One clock: drive at negedge, sample frame_done before the edge, leave 1 time unit after the edge.
    task automatic cycle(input logic e, input logic l, input logic [15:0] b, input logic r);
        @(negedge clk);
        en = e; load = l; bcd_in = b; rst = r;
        #1;
        obs_fd = frame_done;
        exp_fd = model_fd();
        model_step(e, l, b, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 16'h9999, 1'b1);
        cycle(1'b1, 1'b1, 16'h9999, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        total++;
        if ({seg, an, pending, frame_done} !== 13'b0) begin
            bad++;
            $display("FAIL reset: got seg=%b an=%b pending=%b fd=%b want all zero", seg, an, pending, frame_done);
        end
    endtask

    task automatic test_enable_blank();
        int pulses;
        int last_fd;
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < N; k++) begin
            total++;
            if (an !== 4'(1 << k) || seg !== 7'b1111110) begin
                bad++;
                $display("FAIL enable_digit%0d: got an=%b seg=%b want an=%b seg=1111110", k, an, seg, 4'(1 << k));
            end
            repeat (R) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        end
        pulses = 0;
        last_fd = -1;
        for (int i = 0; i < 48; i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b0);
            if (obs_fd) begin
                if (last_fd >= 0 && i - last_fd != 16) begin
                    bad++;
                    $display("FAIL fd_period: got %0d cycles want 16", i - last_fd);
                end
                pulses++;
                last_fd = i;
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL fd_count: got %0d pulses want 3", pulses);
        end
    endtask

    task automatic test_load_idle(input logic [15:0] val, input string name);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b1, val, 1'b0);
        total++;
        if (pending !== 1'b1) begin
            bad++;
            $display("FAIL %s_pend_idle: got %b want 1", name, pending);
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        total++;
        if (pending !== 1'b0) begin
            bad++;
            $display("FAIL %s_pend_entry: got %b want 0", name, pending);
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < N; k++) begin
            total++;
            if (an !== 4'(1 << k) || seg !== ref_digit(val, k)) begin
                bad++;
                $display("FAIL %s_digit%0d: got an=%b seg=%b want an=%b seg=%b",
                         name, k, an, seg, 4'(1 << k), ref_digit(val, k));
            end
            repeat (R) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic test_known_patterns();
        logic [6:0] want_hi;
        test_load_idle(16'h1234, "v1234");
        total++;
        if (ref_digit(16'h1234, 0) !== 7'b0110011 || ref_digit(16'h1234, 3) !== 7'b0110000) begin
            bad++;
            $display("FAIL model_table: got %b %b want 0110011 0110000", ref_digit(16'h1234, 0), ref_digit(16'h1234, 3));
        end
        test_load_idle(16'h1C34, "nibbleC");
        test_load_idle(16'h0042, "lzb");
`ifdef LEADING_ZERO_BLANK_EN
        want_hi = 7'b0000000;
`else
        want_hi = 7'b1111110;
`endif
        // Revisit digit 2 of 0042 directly against the constant expectation.
        for (int i = 0; i < 40 && !(an === 4'b0100); i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        total++;
        if (an !== 4'b0100 || seg !== want_hi) begin
            bad++;
            $display("FAIL lzb_digit2: got an=%b seg=%b want an=0100 seg=%b", an, seg, want_hi);
        end
    endtask

    task automatic test_midframe_load();
        test_load_idle(16'h1234, "pre");
        repeat (5) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h5678, 1'b0);
        total++;
        if (pending !== 1'b1) begin
            bad++;
            $display("FAIL mid_pend: got %b want 1", pending);
        end
        for (int i = 0; i < 40 && !model_fd(); i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b0);
            total++;
            if ({seg, an, pending} !== {m_seg, m_an, m_pending} || an === 4'b0 ||
                seg !== ref_digit(16'h1234, $clog2(an))) begin
                bad++;
                $display("FAIL mid_old: got seg=%b an=%b pend=%b want seg=%b an=%b pend=%b",
                         seg, an, pending, m_seg, m_an, m_pending);
            end
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        total++;
        if (an !== 4'b0001 || seg !== 7'b1111111 || pending !== 1'b0) begin
            bad++;
            $display("FAIL mid_new: got an=%b seg=%b pend=%b want 0001 1111111 0", an, seg, pending);
        end
        cycle(1'b1, 1'b1, 16'h0003, 1'b0);
        for (int i = 0; i < 40 && !model_fd(); i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        if (!model_fd()) begin
            bad++;
            $display("FAIL coincide_wait: got no frame boundary want one within 40 cycles");
        end
        cycle(1'b1, 1'b1, 16'h9999, 1'b0);
        total++;
        if (obs_fd !== 1'b1 || pending !== 1'b1) begin
            bad++;
            $display("FAIL coincide_pend: got fd=%b pend=%b want fd=1 pend=1", obs_fd, pending);
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        total++;
        if (an !== 4'b0001 || seg !== 7'b1111001 || pending !== 1'b1) begin
            bad++;
            $display("FAIL coincide_old: got an=%b seg=%b pend=%b want 0001 1111001 1", an, seg, pending);
        end
        repeat (N*R) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        total++;
        if (an !== 4'b0001 || seg !== 7'b1111011 || pending !== 1'b0) begin
            bad++;
            $display("FAIL coincide_next: got an=%b seg=%b pend=%b want 0001 1111011 0", an, seg, pending);
        end
    endtask

    task automatic test_disable_and_rst();
        test_load_idle(16'h1234, "dis");
        repeat (6) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        total++;
        if (an !== 4'b0 || seg !== 7'b0) begin
            bad++;
            $display("FAIL disable: got an=%b seg=%b want 0000 0000000", an, seg);
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        total++;
        if (an !== 4'b0001 || seg !== 7'b0110011) begin
            bad++;
            $display("FAIL reenable: got an=%b seg=%b want 0001 0110011", an, seg);
        end
        repeat (7) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h8888, 1'b0);
        cycle(1'b1, 1'b1, 16'h7777, 1'b1);
        total++;
        if ({seg, an, pending, frame_done} !== 13'b0) begin
            bad++;
            $display("FAIL rst_mid: got seg=%b an=%b pend=%b fd=%b want all zero", seg, an, pending, frame_done);
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        total++;
        if (an !== 4'b0001 || seg !== 7'b1111110) begin
            bad++;
            $display("FAIL rst_active: got an=%b seg=%b want 0001 1111110", an, seg);
        end
    endtask

    task automatic test_random(input int cycles, input int load_mod, input string name);
        logic e, l, r;
        logic [15:0] b;
        for (int i = 0; i < cycles; i++) begin
            e = ($urandom % 16) != 0;
            l = ($urandom % load_mod) == 0;
            r = ($urandom % 97) == 0;
            b = 16'($urandom);
            cycle(e, l, b, r);
            total++;
            if ({seg, an, pending, obs_fd} !== {m_seg, m_an, m_pending, exp_fd}) begin
                bad++;
                $display("FAIL %s@%0d: got seg=%b an=%b pend=%b fd=%b want seg=%b an=%b pend=%b fd=%b",
                         name, i, seg, an, pending, obs_fd, m_seg, m_an, m_pending, exp_fd);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = '0;
        m_scan = 0; m_t = 0; m_shadow = '0; m_active = '0;
        m_pending = 1'b0; m_seg = '0; m_an = '0;
        test_reset();
        test_enable_blank();
        test_known_patterns();
        test_midframe_load();
        test_disable_and_rst();
        test_random(600, 6, "random");
        test_random(80, 1, "back_to_back");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
